// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard controller bus: decode-side request fields plus the issue/stall/forwarding response.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned PIPE_DEPTH = 3
);
    localparam int unsigned FWD_W = $clog2(PIPE_DEPTH + 1);

    logic                id_valid;
    logic [REG_BITS-1:0] id_rs1;
    logic [REG_BITS-1:0] id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [REG_BITS-1:0] id_rd;
    logic                id_rd_wr;
    logic                id_is_load;
    logic                flush;
    logic                stall;
    logic                issue;
    logic [FWD_W-1:0]    fwd_rs1_sel;
    logic [FWD_W-1:0]    fwd_rs2_sel;
    logic [FWD_W-1:0]    inflight_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_rd_wr, id_is_load, flush,
        input  stall, issue, fwd_rs1_sel, fwd_rs2_sel, inflight_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_rd_wr, id_is_load, flush,
        output stall, issue, fwd_rs1_sel, fwd_rs2_sel, inflight_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight destinations from EX to WB and decides
// whether the ID instruction issues, stalls, or takes a bypassed operand.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_BITS    = 5,
    parameter int unsigned PIPE_DEPTH  = 3,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter bit          FORWARD     = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned FWD_W  = $clog2(PIPE_DEPTH + 1);
    localparam int unsigned LOOK_W = FWD_W + 1;

    logic [PIPE_DEPTH-1:0] r_valid;
    logic [PIPE_DEPTH-1:0] r_wr;
    logic [PIPE_DEPTH-1:0] r_ld;
    logic [REG_BITS-1:0]   r_rd [PIPE_DEPTH];

    logic [LOOK_W-1:0] w_look1;
    logic [LOOK_W-1:0] w_look2;
    logic              w_hazard;
    logic              w_stall;
    logic              w_issue;
    logic [FWD_W-1:0]  w_sel1;
    logic [FWD_W-1:0]  w_sel2;
    logic [FWD_W-1:0]  w_cnt;

    // Returns {load_use, slot+1}; scanning oldest to youngest lets the youngest match win.
    function automatic logic [LOOK_W-1:0] f_lookup(input logic [REG_BITS-1:0] r, input logic use_r);
        logic [LOOK_W-1:0] res;
        res = '0;
        for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
            if (use_r && (r != '0) && r_valid[k] && r_wr[k] && (r_rd[k] == r)) begin
                res = {((k == 0) && r_ld[k]), FWD_W'(k + 1)};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_look1  = f_lookup(bus.id_rs1, bus.id_use_rs1);
        w_look2  = f_lookup(bus.id_rs2, bus.id_use_rs2);
        w_hazard = 1'b0;
        w_sel1   = '0;
        w_sel2   = '0;
        if (FORWARD) begin
            // Only a load still in EX cannot be bypassed.
            w_hazard = w_look1[FWD_W] | w_look2[FWD_W];
            w_sel1   = w_look1[FWD_W-1:0];
            w_sel2   = w_look2[FWD_W-1:0];
        end else begin
            w_hazard = (w_look1[FWD_W-1:0] != '0) | (w_look2[FWD_W-1:0] != '0);
        end
        w_stall = bus.id_valid & ~bus.flush & w_hazard;
        w_issue = bus.id_valid & ~bus.flush & ~w_hazard;
    end

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
            w_cnt = w_cnt + FWD_W'(r_valid[k]);
        end
    end

    // Slots advance every edge; flush squashes the youngest FLUSH_DEPTH slots as they shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_wr    <= '0;
            r_ld    <= '0;
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_valid[0] <= w_issue;
            r_wr[0]    <= w_issue & bus.id_rd_wr & (bus.id_rd != '0);
            r_ld[0]    <= w_issue & bus.id_is_load;
            r_rd[0]    <= bus.id_rd;
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                r_valid[k] <= r_valid[k-1] & ~(bus.flush & (k <= int'(FLUSH_DEPTH)));
                r_wr[k]    <= r_wr[k-1];
                r_ld[k]    <= r_ld[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.issue        = w_issue;
    assign bus.fwd_rs1_sel  = w_sel1;
    assign bus.fwd_rs2_sel  = w_sel2;
    assign bus.inflight_cnt = w_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a bypassing and an interlocked instance share stimulus and are
// compared every cycle against an issue-history model, plus directed scenario checks.
module tb_pipe_hazard_ctrl;
    localparam int unsigned RB = 5;
    localparam int unsigned PD = 3;
    localparam int unsigned FD = 1;

    typedef struct {
        int             c;
        logic [RB-1:0]  rd;
        bit             wr;
        bit             ld;
        bit             dead;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          id_valid, u1, u2, wr, ld, flush;
    logic [RB-1:0] rs1, rs2, rd;

    int   errors = 0;
    int   checks = 0;
    int   now    = 0;
    rec_t q_f[$];
    rec_t q_i[$];
    bit   pred_is_f, pred_is_i;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_BITS(RB), .PIPE_DEPTH(PD)) if_f ();
    pipe_hazard_ctrl_if #(.REG_BITS(RB), .PIPE_DEPTH(PD)) if_i ();

    assign if_f.id_valid = id_valid;  assign if_i.id_valid = id_valid;
    assign if_f.id_rs1 = rs1;         assign if_i.id_rs1 = rs1;
    assign if_f.id_rs2 = rs2;         assign if_i.id_rs2 = rs2;
    assign if_f.id_use_rs1 = u1;      assign if_i.id_use_rs1 = u1;
    assign if_f.id_use_rs2 = u2;      assign if_i.id_use_rs2 = u2;
    assign if_f.id_rd = rd;           assign if_i.id_rd = rd;
    assign if_f.id_rd_wr = wr;        assign if_i.id_rd_wr = wr;
    assign if_f.id_is_load = ld;      assign if_i.id_is_load = ld;
    assign if_f.flush = flush;        assign if_i.flush = flush;

    pipe_hazard_ctrl #(.REG_BITS(RB), .PIPE_DEPTH(PD), .FLUSH_DEPTH(FD), .FORWARD(1'b1)) u_fw (
        .clk(clk), .reset_n(reset_n), .bus(if_f.slave));
    pipe_hazard_ctrl #(.REG_BITS(RB), .PIPE_DEPTH(PD), .FLUSH_DEPTH(FD), .FORWARD(1'b0)) u_il (
        .clk(clk), .reset_n(reset_n), .bus(if_i.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    // Expected outputs from the history of issued instructions: an instruction issued in
    // cycle c sits in slot now-c-1 and is tracked while that slot is below PD.
    task automatic check_mode(input bit fwd);
        rec_t q[$];
        int   k1, k2, cnt, s1, s2;
        bit   l1, l2, haz, st, is;
        if (fwd) q = q_f; else q = q_i;
        k1 = -1; k2 = -1; cnt = 0; l1 = 0; l2 = 0;
        foreach (q[j]) begin
            int s;
            s = now - q[j].c - 1;
            if (!q[j].dead && s < int'(PD)) begin
                cnt++;
                if (q[j].wr && u1 && rs1 != 0 && q[j].rd == rs1 && (k1 < 0 || s < k1)) begin
                    k1 = s; l1 = q[j].ld;
                end
                if (q[j].wr && u2 && rs2 != 0 && q[j].rd == rs2 && (k2 < 0 || s < k2)) begin
                    k2 = s; l2 = q[j].ld;
                end
            end
        end
        haz = fwd ? ((k1 == 0 && l1) || (k2 == 0 && l2)) : (k1 >= 0 || k2 >= 0);
        st  = id_valid && !flush && haz;
        is  = id_valid && !flush && !st;
        s1  = (fwd && k1 >= 0) ? k1 + 1 : 0;
        s2  = (fwd && k2 >= 0) ? k2 + 1 : 0;
        if (fwd) begin
            pred_is_f = is;
            chk("fw_stall", 32'(if_f.stall), 32'(st));
            chk("fw_issue", 32'(if_f.issue), 32'(is));
            chk("fw_cnt", 32'(if_f.inflight_cnt), 32'(cnt));
            if (!st) begin
                chk("fw_sel1", 32'(if_f.fwd_rs1_sel), 32'(s1));
                chk("fw_sel2", 32'(if_f.fwd_rs2_sel), 32'(s2));
            end
        end else begin
            pred_is_i = is;
            chk("il_stall", 32'(if_i.stall), 32'(st));
            chk("il_issue", 32'(if_i.issue), 32'(is));
            chk("il_cnt", 32'(if_i.inflight_cnt), 32'(cnt));
            chk("il_sel1", 32'(if_i.fwd_rs1_sel), 32'(s1));
            chk("il_sel2", 32'(if_i.fwd_rs2_sel), 32'(s2));
        end
    endtask

    task automatic adv_mode(input bit fwd);
        rec_t q[$];
        rec_t r;
        bit   is;
        if (fwd) begin q = q_f; is = pred_is_f; end
        else     begin q = q_i; is = pred_is_i; end
        if (flush) begin
            foreach (q[j]) if (now - q[j].c - 1 < int'(FD)) q[j].dead = 1'b1;
        end
        if (is) begin
            r.c = now; r.rd = rd; r.wr = wr; r.ld = ld; r.dead = 1'b0;
            q.push_back(r);
        end
        if (fwd) q_f = q; else q_i = q;
    endtask

    task automatic cyc_begin(input bit v, input int a1, input bit ua1, input int a2, input bit ua2,
                             input int d, input bit w, input bit l, input bit f);
        @(negedge clk);
        id_valid = v; rs1 = RB'(a1); u1 = ua1; rs2 = RB'(a2); u2 = ua2;
        rd = RB'(d); wr = w; ld = l; flush = f;
        #1;
        check_mode(1'b1);
        check_mode(1'b0);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        if (!reset_n) begin
            q_f.delete(); q_i.delete();
        end else begin
            adv_mode(1'b1);
            adv_mode(1'b0);
        end
        now++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, 0);
            cyc_end();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        idle(2);
        #2 reset_n = 1'b1;

        // Async reset with three writers in flight
        for (int i = 1; i <= 3; i++) begin
            cyc_begin(1, 0, 0, 0, 0, i, 1, 0, 0);
            cyc_end();
        end
        cyc_begin(1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("t1_cnt_before", 32'(if_f.inflight_cnt), 32'd3);
        chk("t1_sel_before", 32'(if_f.fwd_rs1_sel), 32'd3);
        #2 reset_n = 1'b0;
        q_f.delete(); q_i.delete();
        #1;
        check_mode(1'b1);
        check_mode(1'b0);
        chk("t1_cnt", 32'(if_f.inflight_cnt), 32'd0);
        chk("t1_stall", 32'(if_f.stall), 32'd0);
        chk("t1_sel1", 32'(if_f.fwd_rs1_sel), 32'd0);
        chk("t1_issue", 32'(if_f.issue), 32'd1);
        chk("t1_il_stall", 32'(if_i.stall), 32'd0);
        cyc_end();
        #2 reset_n = 1'b1;
        idle(1);

        // Forward chain through EX, MEM, WB
        cyc_begin(1, 0, 0, 0, 0, 5, 1, 0, 0);
        cyc_end();
        for (int i = 1; i <= 4; i++) begin
            cyc_begin(0, 5, 1, 0, 0, 0, 0, 0, 0);
            chk("t2_sel1", 32'(if_f.fwd_rs1_sel), 32'(i % 4));
            chk("t2_stall", 32'(if_f.stall), 32'd0);
            cyc_end();
        end

        // Load-use
        cyc_begin(1, 0, 0, 0, 0, 7, 1, 1, 0);
        cyc_end();
        cyc_begin(1, 0, 0, 7, 1, 0, 0, 0, 0);
        chk("t3_stall", 32'(if_f.stall), 32'd1);
        chk("t3_issue", 32'(if_f.issue), 32'd0);
        cyc_end();
        cyc_begin(1, 0, 0, 7, 1, 0, 0, 0, 0);
        chk("t3_stall2", 32'(if_f.stall), 32'd0);
        chk("t3_sel2", 32'(if_f.fwd_rs2_sel), 32'd2);
        chk("t3_issue2", 32'(if_f.issue), 32'd1);
        cyc_end();
        idle(3);

        // Youngest writer wins; x0 never hazards but occupies a slot
        cyc_begin(1, 0, 0, 0, 0, 5, 1, 0, 0); cyc_end();
        cyc_begin(1, 0, 0, 0, 0, 5, 1, 0, 0); cyc_end();
        cyc_begin(1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("t4_sel_young", 32'(if_f.fwd_rs1_sel), 32'd1);
        chk("t4_il_stall", 32'(if_i.stall), 32'd1);
        cyc_end();
        cyc_begin(1, 0, 0, 0, 0, 0, 1, 0, 0); cyc_end();
        cyc_begin(1, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("t4_x0_stall", 32'(if_f.stall), 32'd0);
        chk("t4_x0_sel", 32'(if_f.fwd_rs1_sel), 32'd0);
        chk("t4_x0_cnt", 32'(if_f.inflight_cnt), 32'd3);
        cyc_end();
        idle(3);

        // Flush squashes ID and slot 0, older slot survives
        cyc_begin(1, 0, 0, 0, 0, 2, 1, 0, 0); cyc_end();
        cyc_begin(1, 0, 0, 0, 0, 3, 1, 0, 0); cyc_end();
        cyc_begin(1, 0, 0, 0, 0, 4, 1, 0, 1);
        chk("t5_issue", 32'(if_f.issue), 32'd0);
        chk("t5_cnt", 32'(if_f.inflight_cnt), 32'd2);
        cyc_end();
        cyc_begin(0, 3, 1, 4, 1, 0, 0, 0, 0);
        chk("t5_sel1", 32'(if_f.fwd_rs1_sel), 32'd0);
        chk("t5_sel2", 32'(if_f.fwd_rs2_sel), 32'd0);
        chk("t5_cnt2", 32'(if_f.inflight_cnt), 32'd1);
        cyc_end();
        idle(3);

        // Interlock holds the reader until the writer leaves WB
        cyc_begin(1, 0, 0, 0, 0, 9, 1, 0, 0); cyc_end();
        for (int i = 0; i < 4; i++) begin
            cyc_begin(1, 9, 1, 0, 0, 0, 0, 0, 0);
            chk("t6_stall", 32'(if_i.stall), (i < 3) ? 32'd1 : 32'd0);
            chk("t6_issue", 32'(if_i.issue), (i < 3) ? 32'd0 : 32'd1);
            chk("t6_sel1", 32'(if_i.fwd_rs1_sel), 32'd0);
            cyc_end();
        end
        idle(3);

        // Random traffic against the history model
        for (int n = 0; n < 400; n++) begin
            cyc_begin($urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                      int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            cyc_end();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
